// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_SKID_EN for a 2-entry skid buffer that removes the out_ready_i -> in_ready_o path.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             accept;
    logic             drain;

    // A stalled stage shows a bubble downstream but keeps its contents.
    assign out_valid_o = out_valid_q & ~stall_i;
    assign out_data_o  = out_data_q;
    assign drain       = out_valid_o & out_ready_i;
    assign accept      = in_valid_i & in_ready_o;

`ifdef PIPE_SKID_EN
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;

    assign in_ready_o = ~stall_i & ~skid_valid_q;
    assign count_o    = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= RESET_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VAL;
        end else if (!stall_i) begin
            if (drain) begin
                // Skid entry is older than any new beat; in_ready_o is low while it is valid.
                if (skid_valid_q) begin
                    out_data_q   <= skid_data_q;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_data_q <= in_data_i;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                if (out_valid_q) begin
                    skid_data_q  <= in_data_i;
                    skid_valid_q <= 1'b1;
                end else begin
                    out_data_q  <= in_data_i;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end
`else
    assign in_ready_o = ~stall_i & (~out_valid_q | out_ready_i);
    assign count_o    = {1'b0, out_valid_q};

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= RESET_VAL;
        end else if (!stall_i) begin
            if (accept) begin
                out_data_q  <= in_data_i;
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed T1-T5 vectors plus a long random run.
module tb_pipe_stage_reg;

    localparam int unsigned      W    = 16;
    localparam logic [W-1:0]     RV   = 16'h0013;
`ifdef PIPE_SKID_EN
    localparam bit               SKID = 1'b1;
`else
    localparam bit               SKID = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         stall_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] in_data_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] out_data_o;
    logic [1:0]   count_o;

    int unsigned  total  = 0;
    int unsigned  passed = 0;
    logic [W-1:0] exp_q[$];

    pipe_stage_reg #(
        .WIDTH    (W),
        .RESET_VAL(RV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .count_o    (count_o)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Output monitor: compares the presented beat and status against the queue head.
    always @(negedge clock) begin
        #3;
        if (!reset) begin
            chk("count", {30'd0, count_o}, exp_q.size());
            chk("out_valid", {31'd0, out_valid_o}, {31'd0, (!stall_i && exp_q.size() > 0)});
            if (SKID)
                chk("in_ready", {31'd0, in_ready_o}, {31'd0, (!stall_i && exp_q.size() < 2)});
            else
                chk("in_ready", {31'd0, in_ready_o},
                    {31'd0, (!stall_i && (exp_q.size() == 0 || out_ready_i))});
            if (out_valid_o && exp_q.size() > 0) begin
                chk("out_data", {16'd0, out_data_o}, {16'd0, exp_q[0]});
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // Input monitor: records accepted beats; reset and flush discard everything held.
    always @(negedge clock) begin
        #4;
        if (reset || flush_i) exp_q.delete();
        else if (!stall_i && in_valid_i && in_ready_o) exp_q.push_back(in_data_i);
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                         input logic st, input logic fl);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        stall_i     = st;
        flush_i     = fl;
        @(negedge clock);
    endtask

    initial begin
        // T1: reset held 2 cycles with in_valid_i high
        in_valid_i = 1'b1;
        in_data_i  = 16'h00FF;
        reset      = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t1_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t1_data", {16'd0, out_data_o}, {16'd0, RV});
        chk("t1_count", {30'd0, count_o}, 32'd0);
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // T2: back-to-back stream
        for (int i = 1; i <= 4; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // T3: backpressure with 0xA held
        drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("t3_data", {16'd0, out_data_o}, 32'h0000_000A);
        chk("t3_count", {30'd0, count_o}, SKID ? 32'd2 : 32'd1);
        chk("t3_ready", {31'd0, in_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // T4: stall while holding 0x5
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        in_valid_i = 1'b1; in_data_i = 16'h0006; out_ready_i = 1'b1; stall_i = 1'b1;
        #3;
        chk("t4_ready", {31'd0, in_ready_o}, 32'd0);
        chk("t4_valid", {31'd0, out_valid_o}, 32'd0);
        @(negedge clock);
        drive(1'b1, 16'h0006, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // T5: flush with a full stage and a beat offered
        drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0012, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
        chk("t5_valid", {31'd0, out_valid_o}, 32'd0);
        chk("t5_count", {30'd0, count_o}, 32'd0);
        chk("t5_data", {16'd0, out_data_o}, {16'd0, RV});
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // T6: random traffic
        for (int i = 0; i < 10000; i++) begin
            logic fl;
            fl = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 1) == 1, W'(16'h0100 + i), fl ? 1'b0 : ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 99) < 15, fl);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t6_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
